// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : uart_pkg                                                   |
// | Description : Shared constants for the UART loopback echo path: default |
// |               byte width, buffer geometry, busy timeout and the drain    |
// |               FSM state encoding.                                        |
// | Ports       : none (package)                                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_DEPTH        = 16;
  localparam int UART_ADDR_W       = 4;
  localparam int UART_BUSY_TIMEOUT = 8;

  // Drain FSM encodings, 2 bits wide.
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = IDLE,
    S_LAUNCH    = LAUNCH,
    S_WAIT_BUSY = WAIT_BUSY,
    S_WAIT_DONE = WAIT_DONE
  } drain_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_echo_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : uart_echo_buffer_if                                        |
// | Description : Receiver/transmitter handshake and status bundle of the   |
// |               echo buffer.                                               |
// | Signals     : i_rx_dv/i_rx_data  receiver strobe and byte                |
// |               i_tx_busy          transmitter busy                        |
// |               o_tx_dv/o_tx_data  launch strobe and byte to transmitter   |
// |               o_last_byte        last received byte (display)            |
// |               o_count/o_full/o_empty/o_overflow  buffer status           |
// | Modports    : master (environment side), slave (echo buffer side)        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface uart_echo_buffer_if #(
  parameter int DATA_W = uart_pkg::UART_DATA_W,
  parameter int ADDR_W = uart_pkg::UART_ADDR_W
);
  logic              i_rx_dv;
  logic [DATA_W-1:0] i_rx_data;
  logic              i_tx_busy;
  logic              o_tx_dv;
  logic [DATA_W-1:0] o_tx_data;
  logic [DATA_W-1:0] o_last_byte;
  logic [ADDR_W:0]   o_count;
  logic              o_full;
  logic              o_empty;
  logic              o_overflow;

  modport master (
    output i_rx_dv, i_rx_data, i_tx_busy,
    input  o_tx_dv, o_tx_data, o_last_byte, o_count, o_full, o_empty, o_overflow
  );

  modport slave (
    input  i_rx_dv, i_rx_data, i_tx_busy,
    output o_tx_dv, o_tx_data, o_last_byte, o_count, o_full, o_empty, o_overflow
  );
endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_sync_fifo                                             |
// | Description : Single-clock FIFO with occupancy count, full/empty and a  |
// |               sticky overflow flag. A write while full is accepted only |
// |               when a pop happens in the same cycle.                      |
// | Ports       : i_clk, i_reset        clock, sync active-high reset        |
// |               i_wr_req, i_wr_data   write strobe and data                |
// |               i_pop                 advance read pointer                 |
// |               o_head                entry at the read pointer            |
// |               o_count, o_full, o_empty, o_overflow  status               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_DEPTH,
  parameter int ADDR_W = UART_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_req,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (count_q == C_DEPTH);
  assign w_empty = (count_q == '0);
  // A pop is never honoured on an empty buffer, so a byte written this
  // cycle into an empty FIFO cannot leave in the same cycle.
  assign w_pop   = i_pop && !w_empty;
  // The slot freed by a same-cycle pop lets a write through even when full.
  assign w_push  = i_wr_req && (!w_full || w_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (i_wr_req && !w_push) overflow_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_push) mem[wr_ptr_q] <= i_wr_data;
  end

  assign o_head     = mem[rd_ptr_q];
  assign o_count    = count_q;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = overflow_q;

endmodule
`default_nettype wire

// File: rtl/uart_echo_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_echo_buffer                                           |
// | Description : Loopback buffer between UART receiver and transmitter.    |
// |               Queues received bytes and launches them one at a time,    |
// |               waiting for the transmitter to go busy and idle again.    |
// |               Also holds the last received byte for the display.        |
// | Ports       : i_clk, i_reset  clock, sync active-high reset              |
// |               bus (slave)     rx strobe/data, tx busy, tx launch/data,   |
// |                               last byte, count, full, empty, overflow    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int DATA_W       = UART_DATA_W,
  parameter int DEPTH        = UART_DEPTH,
  parameter int ADDR_W       = UART_ADDR_W,
  parameter int BUSY_TIMEOUT = UART_BUSY_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  uart_echo_buffer_if.slave bus
);

  localparam int              TMO_W      = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  drain_state_e      state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              tx_dv_q, tx_dv_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] last_byte_q, last_byte_d;

  logic [DATA_W-1:0] w_head;
  logic              w_empty;
  logic              w_pop;
  logic [TMO_W-1:0]  w_tmo_inc;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr_req   (bus.i_rx_dv),
    .i_wr_data  (bus.i_rx_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (bus.o_count),
    .o_full     (bus.o_full),
    .o_empty    (w_empty),
    .o_overflow (bus.o_overflow)
  );

  // The head leaves the FIFO during the launch cycle itself.
  assign w_pop     = (state_q == S_LAUNCH);
  assign w_tmo_inc = tmo_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (!w_empty) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
        tmo_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (bus.i_tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          // Transmitter never acknowledged: treat the byte as sent.
          tmo_d = w_tmo_inc;
          if (w_tmo_inc >= C_TMO_LAST) state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.i_tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Launch strobe and byte are registered on entry to LAUNCH so both are
  // presented together; the byte is the FIFO head, captured before the pop.
  always_comb begin
    tx_dv_d     = (state_d == S_LAUNCH);
    tx_data_d   = tx_data_q;
    last_byte_d = last_byte_q;
    if (state_d == S_LAUNCH) tx_data_d = w_head;
    // Updated on every strobe, including a byte the FIFO drops.
    if (bus.i_rx_dv) last_byte_d = bus.i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      tx_dv_q     <= 1'b0;
      tx_data_q   <= '0;
      last_byte_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      tx_dv_q     <= tx_dv_d;
      tx_data_q   <= tx_data_d;
      last_byte_q <= last_byte_d;
    end
  end

  assign bus.o_tx_dv     = tx_dv_q;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_last_byte = last_byte_q;
  assign bus.o_empty     = w_empty;

endmodule
`default_nettype wire
